// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM port arbiter.
// State and owner encodings plus the byte-to-word address shift.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int WORD_SHIFT = 3;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// arb_rr2: two-way round-robin picker holding its own pointer.
// Index 0 is instruction fetch, index 1 is data; fetch wins the first tie.
module arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // A lone request passes straight through; a tie goes to the pointer side.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // After each grant the pointer prefers the side that was not served.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and load/store.
// Optional counters are enabled with MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int RAM_AW  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  output logic              ram_we,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts,
`endif
  input  logic [63:0]       ram_rdata
);

  localparam int AHI = RAM_AW + WORD_SHIFT - 1;

  arb_state_t        state_q, state_d;
  owner_t            own_q, own_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              hi_q, hi_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       i_rdata_q;
  logic [63:0]       d_rdata_q;
  logic              can_grant;
  logic              done;
  logic [1:0]        grant;
  logic [RAM_AW-1:0] i_word;
  logic [RAM_AW-1:0] d_word;
  logic              unused_bits;

  assign can_grant = (state_q == ARB_IDLE) && !reset;
  assign i_word    = i_addr[AHI:WORD_SHIFT];
  assign d_word    = d_addr[AHI:WORD_SHIFT];

  assign unused_bits = ^{i_addr[ADDR_W-1:AHI+1], i_addr[1:0],
                         d_addr[ADDR_W-1:AHI+1], d_addr[2:0]};

  arb_rr2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({d_req, i_req} & {2{can_grant}}),
    .advance (|grant),
    .grant   (grant)
  );

  assign i_gnt = grant[0];
  assign d_gnt = grant[1];

  assign done     = (state_q == ARB_RD_WAIT) && (cnt_q == 2'd0) && !reset;
  assign i_rvalid = done && (own_q == OWN_I);
  assign d_rvalid = done && (own_q == OWN_D);

  assign i_rdata = i_rvalid ? (hi_q ? ram_rdata[63:32] : ram_rdata[31:0])
                            : i_rdata_q;
  assign d_rdata = d_rvalid ? ram_rdata : d_rdata_q;

  // Next state, RAM drive and read bookkeeping.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant[0]) begin
          ram_addr = i_word;
          addr_d   = i_word;
          own_d    = OWN_I;
          hi_d     = i_addr[2];
          cnt_d    = 2'(RAM_LAT - 1);
          state_d  = ARB_RD_WAIT;
        end else if (grant[1]) begin
          ram_addr = d_word;
          if (d_we) begin
            ram_we    = 1'b1;
            ram_wdata = d_wdata;
          end else begin
            addr_d  = d_word;
            own_d   = OWN_D;
            cnt_d   = 2'(RAM_LAT - 1);
            state_d = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        ram_addr = reset ? '0 : addr_q;
        if (cnt_q == 2'd0) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
  end

  // State register and held read data; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      own_q     <= OWN_I;
      cnt_q     <= 2'd0;
      hi_q      <= 1'b0;
      addr_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      if (i_rvalid) i_rdata_q <= i_rdata;
      if (d_rvalid) d_rdata_q <= d_rdata;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  // Saturating grant and conflict counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (i_gnt && stat_i_grants != '1)
        stat_i_grants <= stat_i_grants + 32'd1;
      if (d_gnt && stat_d_grants != '1)
        stat_d_grants <= stat_d_grants + 32'd1;
      if (can_grant && i_req && d_req && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench, RAM_LAT=1 (a_) and RAM_LAT=3 (b_).
// Counter checks run when MEM_PORT_ARBITER_STATS_EN is defined.
module tb_mem_port_arbiter;

  typedef struct {
    logic        own;
    logic [63:0] data;
    int          t;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_i_req, a_d_req, a_d_we;
  logic [63:0] a_i_addr, a_d_addr, a_d_wdata;
  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_ram_we;
  logic [31:0] a_i_rdata;
  logic [63:0] a_d_rdata, a_ram_wdata, a_ram_rdata;
  logic [7:0]  a_ram_addr;

  logic        b_reset, b_i_req, b_d_req, b_d_we;
  logic [63:0] b_i_addr, b_d_addr, b_d_wdata;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_ram_we;
  logic [31:0] b_i_rdata;
  logic [63:0] b_d_rdata, b_ram_wdata, b_ram_rdata;
  logic [7:0]  b_ram_addr;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] a_si, a_sd, a_sc, b_si, b_sd, b_sc;
`endif

  mem_port_arbiter #(.ADDR_W(64), .RAM_AW(8), .RAM_LAT(1)) u_a (
    .clk(clk), .reset(a_reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt),
    .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
    .d_rdata(a_d_rdata), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .stat_i_grants(a_si), .stat_d_grants(a_sd), .stat_conflicts(a_sc),
`endif
    .ram_rdata(a_ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(64), .RAM_AW(8), .RAM_LAT(3)) u_b (
    .clk(clk), .reset(b_reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt),
    .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .stat_i_grants(b_si), .stat_d_grants(b_sd), .stat_conflicts(b_sc),
`endif
    .ram_rdata(b_ram_rdata)
  );

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  logic [63:0] a_p1, b_p1, b_p2, b_p3;
  bit          loaded = 1'b0;

  assign a_ram_rdata = a_p1;
  assign b_ram_rdata = b_p3;

  function automatic logic [63:0] init_word(input int k);
    if (k == 2) return 64'hDEAD_BEEF_0000_0013;
    return {32'hC0DE_0000 | 32'(k), 32'h0000_1000 | 32'(k)};
  endfunction

  // Synchronous RAM models with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] = init_word(k);
        mem_b[k] = init_word(k);
      end
      loaded = 1'b1;
    end
    a_p1 <= mem_a[a_ram_addr];
    b_p1 <= mem_b[b_ram_addr];
    b_p2 <= b_p1;
    b_p3 <= b_p2;
    if (a_ram_we) mem_a[a_ram_addr] = a_ram_wdata;
    if (b_ram_we) mem_b[b_ram_addr] = b_ram_wdata;
  end

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  sb_t sb_a[$];
  sb_t sb_b[$];
  bit  busy [2];

  task automatic mon(input bit sel, input logic rst,
                     input logic igt, input logic dgt, input logic dwe,
                     input logic irv, input logic drv,
                     input logic [63:0] iaddr, input logic [63:0] iw,
                     input logic [63:0] dw, input logic [31:0] ird,
                     input logic [63:0] drd, input int lat);
    sb_t e;
    logic [63:0] got;
    if (rst) begin
      if (sel) sb_b.delete(); else sb_a.delete();
      busy[sel] = 1'b0;
      return;
    end
    if (irv || drv) begin
      total++;
      got = drv ? drd : {32'h0, ird};
      if ((sel ? sb_b.size() : sb_a.size()) == 0) begin
        bad++;
        $display("FAIL sb_spurious%0d got=%h exp=none", sel, got);
      end else begin
        e = sel ? sb_b.pop_front() : sb_a.pop_front();
        if (e.own !== drv || got !== e.data || (cyc - e.t) != lat) begin
          bad++;
          $display("FAIL sb_read%0d got=%0d/%h/lat%0d exp=%0d/%h/lat%0d",
                   sel, drv, got, cyc - e.t, e.own, e.data, lat);
        end
      end
      busy[sel] = 1'b0;
    end
    if (igt || (dgt && !dwe)) begin
      total++;
      if (busy[sel] || (igt && dgt)) begin
        bad++;
        $display("FAIL grant_excl%0d got=busy%0d/%0d%0d exp=single",
                 sel, busy[sel], igt, dgt);
      end
      e.own  = igt ? 1'b0 : 1'b1;
      e.data = igt ? (iaddr[2] ? {32'h0, iw[63:32]} : {32'h0, iw[31:0]})
                   : dw;
      e.t    = cyc;
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
      busy[sel] = 1'b1;
    end
  endtask

  task automatic smp;
    @(negedge clk);
    cyc++;
    mon(1'b0, a_reset, a_i_gnt, a_d_gnt, a_d_we, a_i_rvalid, a_d_rvalid,
        a_i_addr, mem_a[a_i_addr[10:3]], mem_a[a_d_addr[10:3]],
        a_i_rdata, a_d_rdata, 1);
    mon(1'b1, b_reset, b_i_gnt, b_d_gnt, b_d_we, b_i_rvalid, b_d_rvalid,
        b_i_addr, mem_b[b_i_addr[10:3]], mem_b[b_d_addr[10:3]],
        b_i_rdata, b_d_rdata, 3);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_reset = 1; b_reset = 1;
    a_i_req = 0; a_d_req = 0; a_d_we = 0;
    a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_d_req = 0; b_d_we = 0;
    b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    adv(); adv();
    smp();
    total++;
    if ({a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_ram_we} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b exp=00000",
               {a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_ram_we});
    end
    total++;
    if ({a_i_rdata, a_d_rdata, a_ram_addr, a_ram_wdata} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h/%h exp=0",
               a_i_rdata, a_d_rdata, a_ram_addr, a_ram_wdata);
    end
    adv();
    a_reset = 0; b_reset = 0;
    smp();
    total++;
    if ({a_i_gnt, a_d_gnt, a_ram_we, a_ram_addr} !== '0) begin
      bad++;
      $display("FAIL idle_out got=%b%b%b/%h exp=0",
               a_i_gnt, a_d_gnt, a_ram_we, a_ram_addr);
    end
    adv();
  endtask

  task automatic test_fetch;
    a_i_req = 1; a_i_addr = 64'h14;
    smp();
    total++;
    if (a_i_gnt !== 1'b1 || a_ram_addr !== 8'd2 || a_ram_we !== 1'b0) begin
      bad++;
      $display("FAIL fetch_gnt got=%b/%h/%b exp=1/02/0",
               a_i_gnt, a_ram_addr, a_ram_we);
    end
    adv();
    a_i_req = 0;
    smp();
    total++;
    if (a_i_rvalid !== 1'b1 || a_i_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL fetch_data got=%b/%h exp=1/deadbeef",
               a_i_rvalid, a_i_rdata);
    end
    adv();
  endtask

  task automatic test_tie;
    logic [1:0] exp_g;
    a_reset = 1;
    adv();
    a_reset = 0;
    a_i_req = 1; a_i_addr = 64'h08;
    a_d_req = 1; a_d_we = 0; a_d_addr = 64'h20;
    for (int k = 0; k < 9; k++) begin
      smp();
      exp_g = (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00;
      total++;
      if ({a_d_gnt, a_i_gnt} !== exp_g) begin
        bad++;
        $display("FAIL tie_order%0d got=%b exp=%b", k, {a_d_gnt, a_i_gnt}, exp_g);
      end
      adv();
    end
    a_i_req = 0; a_d_req = 0;
    smp();
    adv();
  endtask

`ifdef MEM_PORT_ARBITER_STATS_EN
  task automatic test_stats;
    total++;
    if (a_sc !== 32'd5 || a_si !== 32'd3 || a_sd !== 32'd2) begin
      bad++;
      $display("FAIL stats got=%0d/%0d/%0d exp=5/3/2", a_sc, a_si, a_sd);
    end
  endtask
`endif

  task automatic test_store;
    a_d_req = 1; a_d_we = 1; a_d_addr = 64'h18;
    a_d_wdata = 64'h1122334455667788;
    smp();
    total++;
    if (a_d_gnt !== 1'b1 || a_ram_we !== 1'b1 || a_ram_addr !== 8'd3 ||
        a_ram_wdata !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL store_gnt got=%b/%b/%h/%h exp=1/1/03/1122334455667788",
               a_d_gnt, a_ram_we, a_ram_addr, a_ram_wdata);
    end
    adv();
    a_d_req = 0; a_d_we = 0;
    a_i_req = 1; a_i_addr = 64'h18;
    smp();
    total++;
    if (a_i_gnt !== 1'b1 || a_ram_we !== 1'b0 || a_d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL store_b2b got=%b/%b/%b exp=1/0/0",
               a_i_gnt, a_ram_we, a_d_rvalid);
    end
    adv();
    a_i_req = 0;
    smp();
    total++;
    if (a_i_rvalid !== 1'b1 || a_i_rdata !== 32'h55667788) begin
      bad++;
      $display("FAIL store_fetch got=%b/%h exp=1/55667788",
               a_i_rvalid, a_i_rdata);
    end
    adv();
    a_d_req = 1; a_d_we = 0; a_d_addr = 64'h18;
    smp();
    adv();
    a_d_req = 0;
    smp();
    total++;
    if (a_d_rvalid !== 1'b1 || a_d_rdata !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL store_load got=%b/%h exp=1/1122334455667788",
               a_d_rvalid, a_d_rdata);
    end
    adv();
  endtask

  task automatic test_lat3;
    b_i_req = 1; b_i_addr = 64'h14;
    smp();
    total++;
    if (b_i_gnt !== 1'b1) begin
      bad++;
      $display("FAIL lat3_gnt got=%b exp=1", b_i_gnt);
    end
    adv();
    b_i_req = 0;
    b_d_req = 1; b_d_we = 0; b_d_addr = 64'h28;
    for (int k = 1; k <= 4; k++) begin
      smp();
      total++;
      if (b_d_gnt !== (k == 4) || b_i_rvalid !== (k == 3)) begin
        bad++;
        $display("FAIL lat3_t%0d got=%b/%b exp=%b/%b", k,
                 b_d_gnt, b_i_rvalid, k == 4, k == 3);
      end
      if (k == 3) begin
        total++;
        if (b_i_rdata !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL lat3_data got=%h exp=deadbeef", b_i_rdata);
        end
      end
      adv();
    end
    b_d_req = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      adv();
    end
  endtask

  task automatic test_reset_mid;
    b_i_req = 1; b_i_addr = 64'h08;
    smp();
    total++;
    if (b_i_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt got=%b exp=1", b_i_gnt);
    end
    adv();
    b_i_req = 0; b_reset = 1;
    smp();
    adv();
    b_reset = 0;
    smp();
    adv();
    smp();
    total++;
    if ({b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid, b_ram_we} !== 5'b0 ||
        {b_i_rdata, b_d_rdata, b_ram_addr, b_ram_wdata} !== '0) begin
      bad++;
      $display("FAIL rmid_out got=%b%b%b%b%b/%h/%h/%h/%h exp=0",
               b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid, b_ram_we,
               b_i_rdata, b_d_rdata, b_ram_addr, b_ram_wdata);
    end
    adv();
    b_i_req = 1; b_d_req = 1; b_d_we = 0; b_d_addr = 64'h30;
    smp();
    total++;
    if ({b_d_gnt, b_i_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL rmid_tie got=%b exp=01", {b_d_gnt, b_i_gnt});
    end
    adv();
    b_i_req = 0; b_d_req = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      adv();
    end
  endtask

  task automatic test_drain;
    total++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d/%0d exp=0/0", sb_a.size(), sb_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_tie();
`ifdef MEM_PORT_ARBITER_STATS_EN
    test_stats();
`endif
    test_store();
    test_lat3();
    test_reset_mid();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
